imem_loader: RTL and testbench

Boot-time writer for the pipelined core's instruction memory. Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and issues one write per word to the instruction memory's write port at consecutive word-aligned byte addresses. Holds the core in reset (cpu_hold) until a complete image has been written, then releases it.

---
 rtl/riscv_pkg.sv | 19 +
 rtl/byte_to_word_packer.sv | 55 +++++
 rtl/imem_loader.sv | 171 +++++++++++++++++
 tb/tb_imem_loader.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Holds the loader state encoding, instruction-memory geometry and the datapath width.
package riscv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned IMEM_DEPTH = 81;
    localparam logic [XLEN-1:0] IMEM_BASE = 32'h0000_0000;
    localparam int unsigned IMEM_CNT_W = 16;

    typedef enum logic [2:0] {
        LD_HDR0 = 3'd0,
        LD_HDR1 = 3'd1,
        LD_DATA = 3'd2,
        LD_CHK  = 3'd3,
        LD_DONE = 3'd4,
        LD_ERR  = 3'd5
    } ld_state_e;

endpackage

// File: rtl/byte_to_word_packer.sv
// Assembles accepted bytes into little-endian 32-bit words.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   clr          - synchronous clear for a restarted load
//   accept       - a payload byte is taken this cycle
//   data         - the payload byte
//   last_byte_c  - combinational: the next accepted byte completes a word
//   word_valid   - one-cycle pulse, the cycle after the 4th byte is accepted
//   word         - the completed word (held until the next word completes)
module byte_to_word_packer
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            accept,
    input  logic [7:0]      data,
    output logic            last_byte_c,
    output logic            word_valid,
    output logic [XLEN-1:0] word
);

    logic [1:0]  idx;
    logic [23:0] lanes;

    assign last_byte_c = (idx == 2'd3);

    // Lower three lanes are staged; the 4th byte publishes the word so that
    // the output stays stable while the next word is being collected.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            idx        <= 2'd0;
            lanes      <= 24'd0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= 1'b0;
            if (accept) begin
                if (last_byte_c) begin
                    word       <= {data, lanes};
                    word_valid <= 1'b1;
                    idx        <= 2'd0;
                end else begin
                    case (idx)
                        2'd0:    lanes[7:0]   <= data;
                        2'd1:    lanes[15:8]  <= data;
                        default: lanes[23:16] <= data;
                    endcase
                    idx <= idx + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: header (word count, LSB first) then
// little-endian payload words, one memory write per word. Holds the core in
// reset until a full image has been written.
// Optional: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   start                  - restart pulse, honoured in DONE/ERR only
//   in_valid/in_data       - byte stream; in_ready is combinational from state
//   imem_we/addr/wdata     - instruction-memory write port
//   cpu_hold               - keeps the core in reset
//   load_done, load_err    - load status
module imem_loader
    import riscv_pkg::*;
#(
    parameter int unsigned     DEPTH     = IMEM_DEPTH,
    parameter logic [XLEN-1:0] BASE_ADDR = IMEM_BASE,
    parameter int unsigned     CNT_W     = IMEM_CNT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            in_valid,
    input  logic [7:0]      in_data,
    output logic            in_ready,
    output logic            imem_we,
    output logic [XLEN-1:0] imem_addr,
    output logic [XLEN-1:0] imem_wdata,
    output logic            cpu_hold,
    output logic            load_done,
    output logic            load_err
);

    localparam logic [CNT_W-1:0] DEPTH_N   = CNT_W'(DEPTH);
    localparam logic [XLEN-1:0]  LAST_ADDR = BASE_ADDR + XLEN'(4 * DEPTH - 4);

    ld_state_e        state, next_state;
    logic [7:0]       n_lo;
    logic [CNT_W-1:0] n_words;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] n_full;
    logic             hs;
    logic             restart;
    logic             pk_accept;
    logic             pk_last;
    logic             last_word;
    logic             done_d, err_d, hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]       xsum;
`endif

    assign hs        = in_valid && in_ready;
    assign restart   = start && ((state == LD_DONE) || (state == LD_ERR));
    assign n_full    = CNT_W'({in_data, n_lo});
    assign pk_accept = hs && (state == LD_DATA);
    assign last_word = (word_cnt == n_words - CNT_W'(1));

    // Byte acceptance depends on state only.
    always_comb begin
        in_ready = 1'b0;
        case (state)
            LD_HDR0, LD_HDR1, LD_DATA: in_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            LD_CHK:                    in_ready = 1'b1;
`endif
            default:                   in_ready = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= LD_HDR0;
        else     state <= next_state;
    end

    // Next-state logic; the final transition is taken on the last byte so
    // no further byte is accepted during the final write cycle.
    always_comb begin
        next_state = state;
        case (state)
            LD_HDR0: if (hs) next_state = LD_HDR1;
            LD_HDR1: begin
                if (hs) begin
                    if (n_full == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        next_state = LD_CHK;
`else
                        next_state = LD_DONE;
`endif
                    end else if (n_full > DEPTH_N) begin
                        next_state = LD_ERR;
                    end else begin
                        next_state = LD_DATA;
                    end
                end
            end
            LD_DATA: begin
                if (pk_accept && pk_last && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    next_state = LD_CHK;
`else
                    next_state = LD_DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            LD_CHK:  if (hs) next_state = (in_data == xsum) ? LD_DONE : LD_ERR;
`endif
            LD_DONE, LD_ERR: if (start) next_state = LD_HDR0;
            default: next_state = LD_HDR0;
        endcase
    end

    // Status outputs follow the state one cycle later; start clears them.
    always_comb begin
        done_d = (state == LD_DONE) && !start;
        err_d  = (state == LD_ERR) && !start;
        hold_d = !done_d;
    end

    // Status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_done <= 1'b0;
            load_err  <= 1'b0;
            cpu_hold  <= 1'b1;
        end else begin
            load_done <= done_d;
            load_err  <= err_d;
            cpu_hold  <= hold_d;
        end
    end

    // Header capture, word counting and write addressing.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            n_lo      <= 8'd0;
            n_words   <= '0;
            word_cnt  <= '0;
            imem_addr <= BASE_ADDR;
        end else begin
            if (hs && (state == LD_HDR0)) n_lo    <= in_data;
            if (hs && (state == LD_HDR1)) n_words <= n_full;
            if (pk_accept && pk_last)     word_cnt <= word_cnt + CNT_W'(1);
            // Advance after each write, saturating at the last memory word.
            if (imem_we && (imem_addr != LAST_ADDR)) imem_addr <= imem_addr + XLEN'(4);
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR over header and payload bytes.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            xsum <= 8'd0;
        end else if (hs && (state != LD_CHK)) begin
            xsum <= (state == LD_HDR0) ? in_data : (xsum ^ in_data);
        end
    end
`endif

    byte_to_word_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .clr         (restart),
        .accept      (pk_accept),
        .data        (in_data),
        .last_byte_c (pk_last),
        .word_valid  (imem_we),
        .word        (imem_wdata)
    );

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and randomized byte streams
// compared against a stream-level model of the expected writes and status.
// Honours IMEM_LOADER_CHECKSUM_EN when the design is built with it.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    int errors = 0;
    int checks = 0;

    logic [7:0]  stim[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    always #5 clk = ~clk;

    imem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    // Record every memory write seen mid-cycle.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    // Offer one byte after 'gap' idle cycles; returns after its handshake.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        for (int i = 0; i < gap; i++) tick();
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("ready_timeout", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_stim(input int max_gap);
        foreach (stim[i]) send_byte(stim[i], int'($urandom_range(0, max_gap)));
    endtask

    task automatic add_checksum();
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        foreach (stim[i]) x = x ^ stim[i];
        stim.push_back(x);
`endif
    endtask

    // Header for n words followed by random payload (and checksum if enabled).
    task automatic build_random(input int n);
        stim.delete();
        stim.push_back(8'(n));
        stim.push_back(8'(n >> 8));
        for (int i = 0; i < 4 * n; i++) stim.push_back(8'($urandom_range(0, 255)));
        if (n <= 81) add_checksum();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Stream-level reference: word count from header, words assembled LSB
    // first, addresses 4*k from zero, status from the count (and checksum).
    task automatic model_check(input string tag);
        int  n;
        int  n_wr;
        bit  exp_err;
        int  wait_n;
        logic [31:0] w;
        logic [7:0]  x;
        n = int'(stim[0]) + 256 * int'(stim[1]);
        exp_err = (n > 81);
        n_wr = exp_err ? 0 : n;
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (!exp_err) begin
            x = 8'h00;
            for (int i = 0; i < 2 + 4 * n; i++) x = x ^ stim[i];
            if (x != stim[2 + 4 * n]) exp_err = 1'b1;
        end
`else
        x = 8'h00;
`endif
        wait_n = 0;
        while (!(load_done === 1'b1 || load_err === 1'b1) && wait_n < 30) begin
            tick();
            wait_n++;
        end
        chk({tag, ":done"}, {31'b0, load_done}, {31'b0, !exp_err});
        chk({tag, ":err"}, {31'b0, load_err}, {31'b0, exp_err});
        chk({tag, ":hold"}, {31'b0, cpu_hold}, {31'b0, exp_err});
        chk({tag, ":ready"}, {31'b0, in_ready}, 32'd0);
        chk({tag, ":nwr"}, 32'(wr_addr_q.size()), 32'(n_wr));
        for (int k = 0; k < n_wr && k < wr_addr_q.size(); k++) begin
            w = {stim[5 + 4 * k], stim[4 + 4 * k], stim[3 + 4 * k], stim[2 + 4 * k]};
            chk($sformatf("%s:addr%0d", tag, k), wr_addr_q[k], 32'(4 * k));
            chk($sformatf("%s:data%0d", tag, k), wr_data_q[k], w);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) tick();
        chk("rst:we", {31'b0, imem_we}, 32'd0);
        chk("rst:addr", imem_addr, 32'h0);
        chk("rst:wdata", imem_wdata, 32'h0);
        chk("rst:hold", {31'b0, cpu_hold}, 32'd1);
        chk("rst:done", {31'b0, load_done}, 32'd0);
        chk("rst:err", {31'b0, load_err}, 32'd0);
        chk("rst:ready", {31'b0, in_ready}, 32'd1);
        rst = 1'b0;
        tick();

        // Two-word image, back to back.
        clear_log();
        stim = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00};
        add_checksum();
        send_stim(0);
        model_check("two");
        chk("two:w0", wr_data_q.size() > 0 ? wr_data_q[0] : 32'hx, 32'h0000_0093);
        chk("two:w1", wr_data_q.size() > 1 ? wr_data_q[1] : 32'hx, 32'h0010_0113);

        // Bytes offered in DONE are ignored.
        in_valid = 1'b1; in_data = 8'h55;
        repeat (5) tick();
        in_valid = 1'b0;
        chk("done_ign:nwr", 32'(wr_addr_q.size()), 32'd2);
        chk("done_ign:done", {31'b0, load_done}, 32'd1);

        // Restart from DONE.
        pulse_start();
        chk("rs1:ready", {31'b0, in_ready}, 32'd1);
        chk("rs1:done", {31'b0, load_done}, 32'd0);
        chk("rs1:hold", {31'b0, cpu_hold}, 32'd1);
        chk("rs1:addr", imem_addr, 32'h0);

        // Empty image.
        clear_log();
        stim = '{8'h00, 8'h00};
        add_checksum();
        send_stim(0);
        model_check("empty");
        pulse_start();

        // Oversized image is rejected.
        clear_log();
        stim = '{8'h52, 8'h00};
        send_stim(0);
        model_check("big");
        pulse_start();
        chk("rs2:ready", {31'b0, in_ready}, 32'd1);
        chk("rs2:err", {31'b0, load_err}, 32'd0);
        chk("rs2:hold", {31'b0, cpu_hold}, 32'd1);

        // N=3 with in_valid toggling.
        clear_log();
        build_random(3);
        send_stim(2);
        model_check("n3");
        pulse_start();

        // A few random sizes and gaps.
        for (int r = 0; r < 4; r++) begin
            clear_log();
            build_random(int'($urandom_range(1, 6)));
            send_stim(int'($urandom_range(0, 3)));
            model_check($sformatf("rnd%0d", r));
            pulse_start();
        end

        // Full-depth image: last address 0x140.
        clear_log();
        build_random(81);
        send_stim(0);
        model_check("full");
        pulse_start();

        // Reset mid-word, then a fresh one-word image.
        stim = '{8'h02, 8'h00, 8'ha1, 8'hb2, 8'hc3, 8'hd4, 8'he5, 8'hf6};
        send_stim(0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst:we", {31'b0, imem_we}, 32'd0);
        chk("mrst:addr", imem_addr, 32'h0);
        chk("mrst:wdata", imem_wdata, 32'h0);
        chk("mrst:hold", {31'b0, cpu_hold}, 32'd1);
        chk("mrst:done", {31'b0, load_done}, 32'd0);
        chk("mrst:err", {31'b0, load_err}, 32'd0);
        chk("mrst:ready", {31'b0, in_ready}, 32'd1);
        tick();
        clear_log();
        stim = '{8'h01, 8'h00, 8'h37, 8'h05, 8'h00, 8'h80};
        add_checksum();
        send_stim(1);
        model_check("fresh");

`ifdef IMEM_LOADER_CHECKSUM_EN
        pulse_start();
        clear_log();
        stim = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00, 8'h92};
        send_stim(0);
        model_check("cs_ok");
        chk("cs_ok:done", {31'b0, load_done}, 32'd1);
        pulse_start();
        clear_log();
        stim = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00, 8'h00};
        send_stim(0);
        model_check("cs_bad");
        chk("cs_bad:err", {31'b0, load_err}, 32'd1);
        chk("cs_bad:hold", {31'b0, cpu_hold}, 32'd1);
        chk("cs_bad:nwr", 32'(wr_addr_q.size()), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
